// File: rtl/env_play_pkg.sv
// rtl/env_play_pkg.sv - shared FSM state type and default parameters for env_play
package env_play_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int NSLICE_DEF = 16;
  localparam int ADDRW_DEF  = 12;
  localparam int RDLAT_DEF  = 2;

endpackage

// File: rtl/env_play_vpipe.sv
// rtl/env_play_vpipe.sv - valid/last shift register that tracks reads through the memory latency
module env_play_vpipe #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  input  logic in_last,
  output logic cap_valid,
  output logic out_valid,
  output logic out_last
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] last_q, last_d;

  always_comb begin
    valid_d = {valid_q[DEPTH-2:0], in_valid};
    last_d  = {last_q[DEPTH-2:0], in_valid & in_last};
    if (flush) begin
      valid_d = '0;
      last_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // cap_valid lines up with memdata; out_valid is one register later
  assign cap_valid = valid_q[DEPTH-2];
  assign out_valid = valid_q[DEPTH-1];
  assign out_last  = last_q[DEPTH-1];

endmodule

// File: rtl/env_play.sv
// rtl/env_play.sv - envelope playback engine; ENV_PLAY_LOOP_EN adds nloop repeat playback
module env_play
  import env_play_pkg::*;
#(
  parameter int NSLICE = NSLICE_DEF,
  parameter int ADDRW  = ADDRW_DEF,
  parameter int RDLAT  = RDLAT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDRW-1:0]      envaddr,
  input  logic [ADDRW-1:0]      envlen,
`ifdef ENV_PLAY_LOOP_EN
  input  logic [7:0]            nloop,
`endif
  input  logic                  abort,
  output logic [ADDRW-1:0]      memaddr,
  output logic                  memrd,
  input  logic [NSLICE*32-1:0]  memdata,
  output logic [NSLICE*32-1:0]  envxy32x16,
  output logic                  envvalid,
  output logic                  busy,
  output logic                  done
);

  state_e               state_q, state_d;
  logic [ADDRW-1:0]     addr_q, addr_d;
  logic [ADDRW-1:0]     rem_q, rem_d;
  logic [ADDRW-1:0]     base_q, base_d;
  logic [ADDRW-1:0]     len_q, len_d;
  logic                 done_q, done_d;
  logic [NSLICE*32-1:0] data_q, data_d;
`ifdef ENV_PLAY_LOOP_EN
  logic [7:0]           loop_q, loop_d;
`endif
  logic                 flush;
  logic                 last_rd;
  logic                 cap_valid, out_valid, out_last;

  assign memrd      = (state_q == ST_READ);
  assign memaddr    = addr_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign envvalid   = out_valid;
  assign envxy32x16 = data_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    base_d  = base_q;
    len_d   = len_q;
    done_d  = 1'b0;
    flush   = 1'b0;
    last_rd = 1'b0;
`ifdef ENV_PLAY_LOOP_EN
    loop_d  = loop_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // abort outranks a coincident start even though IDLE has nothing to stop
        if (start && !abort) begin
          if (envlen != '0) begin
            state_d = ST_READ;
            addr_d  = envaddr;
            base_d  = envaddr;
            rem_d   = envlen;
            len_d   = envlen;
`ifdef ENV_PLAY_LOOP_EN
            loop_d  = nloop;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          addr_d = addr_q + ADDRW'(1);
          rem_d  = rem_q - ADDRW'(1);
          if (rem_q == ADDRW'(1)) begin
`ifdef ENV_PLAY_LOOP_EN
            if (loop_q != 8'd0) begin
              addr_d = base_q;
              rem_d  = len_q;
              loop_d = loop_q - 8'd1;
            end else begin
              last_rd = 1'b1;
              state_d = ST_DRAIN;
            end
`else
            last_rd = 1'b1;
            state_d = ST_DRAIN;
`endif
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else if (out_valid && out_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    data_d = '0;
    if (!flush && cap_valid) data_d = memdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      base_q  <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      data_q  <= '0;
`ifdef ENV_PLAY_LOOP_EN
      loop_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      base_q  <= base_d;
      len_q   <= len_d;
      done_q  <= done_d;
      data_q  <= data_d;
`ifdef ENV_PLAY_LOOP_EN
      loop_q  <= loop_d;
`endif
    end
  end

  env_play_vpipe #(
    .DEPTH(RDLAT + 1)
  ) u_vpipe (
    .clk      (clk),
    .rst_n    (reset),
    .flush    (flush),
    .in_valid (memrd),
    .in_last  (last_rd),
    .cap_valid(cap_valid),
    .out_valid(out_valid),
    .out_last (out_last)
  );

endmodule

// File: tb/tb_env_play.sv
// tb/tb_env_play.sv - directed scoreboard bench for env_play
module tb_env_play;

  localparam int NS = 2;
  localparam int AW = 12;
  localparam int RL = 2;
  localparam int DW = NS * 32;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [AW-1:0] envaddr, envlen, memaddr;
  logic          memrd, envvalid, busy, done;
  logic [DW-1:0] memdata, envxy;
`ifdef ENV_PLAY_LOOP_EN
  logic [7:0]    nloop;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [AW-1:0] exp_a[$];
  logic [DW-1:0] exp_d[$];

  always #5 clk = ~clk;

  env_play #(.NSLICE(NS), .ADDRW(AW), .RDLAT(RL)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .envaddr   (envaddr),
    .envlen    (envlen),
`ifdef ENV_PLAY_LOOP_EN
    .nloop     (nloop),
`endif
    .abort     (abort),
    .memaddr   (memaddr),
    .memrd     (memrd),
    .memdata   (memdata),
    .envxy32x16(envxy),
    .envvalid  (envvalid),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {a, 4'hC, a ^ 12'h5A5, 4'h3, ~a, 4'h9, a + 12'h111, 4'h6};
  endfunction

  // memory model with fixed read latency RL
  logic [RL-1:0] rd_v = '0;
  logic [AW-1:0] rd_a [RL];
  always @(posedge clk) begin
    rd_v[0] <= memrd;
    rd_a[0] <= memaddr;
    for (int i = 1; i < RL; i++) begin
      rd_v[i] <= rd_v[i-1];
      rd_a[i] <= rd_a[i-1];
    end
  end
  assign memdata = rd_v[RL-1] ? pat(rd_a[RL-1]) : {NS{32'hBAD0_0BAD}};

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] addr, input int len, input int passes);
    logic [AW-1:0] a;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < len; i++) begin
        a = addr + AW'(i);
        exp_a.push_back(a);
        exp_d.push_back(pat(a));
      end
  endtask

  task automatic go(input logic [AW-1:0] addr, input logic [AW-1:0] len);
    envaddr = addr;
    envlen  = len;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (done !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", done, 1'b1);
  endtask

  task automatic drained(input string tag);
    chk({tag, "_addrq"}, exp_a.size(), 0);
    chk({tag, "_dataq"}, exp_d.size(), 0);
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (memrd === 1'b1) begin
      if (exp_a.size() == 0) chk("memrd_unexpected", memrd, 1'b0);
      else chk("memaddr", memaddr, exp_a.pop_front());
    end
    if (envvalid === 1'b1) begin
      if (exp_d.size() == 0) chk("envvalid_unexpected", envvalid, 1'b0);
      else chk("envdata", envxy, exp_d.pop_front());
    end else begin
      chk("envdata_zero", envxy, '0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, vcnt, rises;
    logic prev;
    reset = 1'b1; start = 1'b0; abort = 1'b0; envaddr = '0; envlen = '0;
`ifdef ENV_PLAY_LOOP_EN
    nloop = 8'd0;
`endif
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_memrd", memrd, 1'b0);
    chk("rst_memaddr", memaddr, '0);
    chk("rst_envxy", envxy, '0);
    chk("rst_envvalid", envvalid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // scenario 1: basic timing
    push(12'h010, 4, 1);
    go(12'h010, 12'd4);
    chk("s1_busy_c1", busy, 1'b1);
    chk("s1_memrd_c1", memrd, 1'b1);
    chk("s1_memaddr_c1", memaddr, 12'h010);
    repeat (2) @(negedge clk);
    chk("s1_envvalid_c3", envvalid, 1'b0);
    @(negedge clk);
    chk("s1_envvalid_c4", envvalid, 1'b1);
    repeat (3) @(negedge clk);
    chk("s1_envvalid_c7", envvalid, 1'b1);
    chk("s1_done_c7", done, 1'b0);
    @(negedge clk);
    chk("s1_done_c8", done, 1'b1);
    chk("s1_busy_c8", busy, 1'b0);
    chk("s1_envvalid_c8", envvalid, 1'b0);
    @(negedge clk);
    chk("s1_done_c9", done, 1'b0);
    drained("s1");

    // scenario 2: address wrap
    push(12'hFFE, 4, 1);
    go(12'hFFE, 12'd4);
    wait_done(20);
    @(negedge clk);
    drained("s2");

    // scenario 3: zero length
    go(12'h055, 12'd0);
    chk("s3_done", done, 1'b1);
    chk("s3_busy", busy, 1'b0);
    chk("s3_memrd", memrd, 1'b0);
    @(negedge clk);
    chk("s3_done_clr", done, 1'b0);

    // scenario 4: abort during READ, then restart
    push(12'h300, 8, 1);
    go(12'h300, 12'd8);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    abort = 1'b0;
    chk("s4_memrd", memrd, 1'b0);
    chk("s4_envvalid", envvalid, 1'b0);
    chk("s4_busy", busy, 1'b0);
    #1;
    exp_a.delete();
    exp_d.delete();
    @(negedge clk);
    chk("s4_envvalid_c5", envvalid, 1'b0);
    @(negedge clk);
    push(12'h400, 2, 1);
    go(12'h400, 12'd2);
    wait_done(20);
    @(negedge clk);
    chk("s4_one_done", done_cnt, d0 + 1);
    drained("s4");

    // scenario 5: start while busy ignored, start on done accepted
    push(12'h100, 3, 1);
    go(12'h100, 12'd3);
    envaddr = 12'h200; envlen = 12'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("s5_busy", busy, 1'b1);
    wait_done(20);
    push(12'h180, 2, 1);
    go(12'h180, 12'd2);
    chk("s5_busy_restart", busy, 1'b1);
    repeat (RL) @(negedge clk);
    chk("s5_envvalid_early", envvalid, 1'b0);
    @(negedge clk);
    chk("s5_envvalid_first", envvalid, 1'b1);
    wait_done(20);
    @(negedge clk);
    drained("s5");

    // abort coincident with start in IDLE
    envaddr = 12'h020; envlen = 12'd3; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abidle_busy", busy, 1'b0);
    chk("abidle_memrd", memrd, 1'b0);

    // reset mid-playback
    push(12'h500, 6, 1);
    go(12'h500, 12'd6);
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_envvalid", envvalid, 1'b0);
    chk("rstmid_envxy", envxy, '0);
    chk("rstmid_memrd", memrd, 1'b0);
    chk("rstmid_memaddr", memaddr, '0);
    chk("rstmid_busy", busy, 1'b0);
    exp_a.delete();
    exp_d.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_idle", busy, 1'b0);

    // maximum length
    push(12'h000, 4095, 1);
    go(12'h000, 12'hFFF);
    wait_done(4200);
    @(negedge clk);
    drained("maxlen");

`ifdef ENV_PLAY_LOOP_EN
    // scenario 6: looped playback
    nloop = 8'd2;
    push(12'h700, 3, 3);
    d0 = done_cnt;
    vcnt = 0; rises = 0; prev = 1'b0;
    go(12'h700, 12'd3);
    nloop = 8'd0;
    for (int n = 0; n < 40 && done !== 1'b1; n++) begin
      if (envvalid === 1'b1) vcnt++;
      if (envvalid === 1'b1 && !prev) rises++;
      prev = envvalid;
      @(negedge clk);
    end
    chk("s6_done", done, 1'b1);
    chk("s6_vcnt", vcnt, 9);
    chk("s6_contig", rises, 1);
    @(negedge clk);
    chk("s6_one_done", done_cnt, d0 + 1);
    drained("s6");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
